// File: rtl/hp_pkg.sv
// Shared types and colour constants for the HP bar controller.
package hp_pkg;

  typedef enum logic [1:0] {
    StOff,
    StGame,
    StInvuln,
    StDead
  } hp_state_e;

  localparam logic [11:0] C_FRAME = 12'hfff;
  localparam logic [11:0] C_OK    = 12'h0f0;
  localparam logic [11:0] C_LOW   = 12'hf00;

endpackage

// File: rtl/hp_edge_det.sv
// Rising-edge detector: one-cycle pulse per low-to-high transition of sig_i.
module hp_edge_det (
  input  logic pclk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/hp_bar_ctrl.sv
// Player HP tracker with invulnerability frames, plus a framed HP-bar overlay
// inserted into the VGA pixel stream with one cycle of latency.
module hp_bar_ctrl
  import hp_pkg::*;
#(
  parameter int unsigned MAX_HP   = 5,
  parameter int unsigned SEG_W    = 60,
  parameter int unsigned BAR_LEFT = 361,
  parameter int unsigned BAR_TOP  = 737,
  parameter int unsigned BAR_H    = 50,
  parameter int unsigned BORDER   = 10,
  parameter int unsigned IFRAMES  = 60,
  parameter int unsigned LOW_HP   = 1,
  localparam int unsigned HPW     = $clog2(MAX_HP + 1)
) (
  input  logic           pclk,
  input  logic           rst_n,
  input  logic           game_on,
  input  logic           player_hit,
  input  logic           heal,
  input  logic [11:0]    hcount_in,
  input  logic [11:0]    vcount_in,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic           hblnk_in,
  input  logic           vblnk_in,
  input  logic [11:0]    rgb_in,
  output logic [11:0]    hcount_out,
  output logic [11:0]    vcount_out,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic           hblnk_out,
  output logic           vblnk_out,
  output logic [11:0]    rgb_out,
  output logic [HPW-1:0] hp_out,
  output logic           invuln,
  output logic           game_over
);

  localparam int unsigned IcW   = $clog2(IFRAMES + 1);
  localparam int unsigned IntR  = BAR_LEFT + MAX_HP * SEG_W;

  localparam logic [11:0] XOutL = 12'(BAR_LEFT - BORDER);
  localparam logic [11:0] XOutR = 12'(IntR + BORDER);
  localparam logic [11:0] YOutT = 12'(BAR_TOP - BORDER);
  localparam logic [11:0] YOutB = 12'(BAR_TOP + BAR_H + BORDER);
  localparam logic [11:0] XIntL = 12'(BAR_LEFT);
  localparam logic [11:0] XIntR = 12'(IntR);
  localparam logic [11:0] YIntT = 12'(BAR_TOP);
  localparam logic [11:0] YIntB = 12'(BAR_TOP + BAR_H);

  localparam logic [HPW-1:0] HpMax = HPW'(MAX_HP);
  localparam logic [HPW-1:0] HpLow = HPW'(LOW_HP);

  hp_state_e      state_q;
  logic [HPW-1:0] hp_q;
  logic [IcW-1:0] icnt_q;
  logic [2:0]     blink_q;
  logic           invuln_q;
  logic           game_over_q;
  logic           vblnk_q;

  logic hit_rise;
  logic heal_rise;
  logic tick;

  hp_edge_det u_hit_edge (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .sig_i  (player_hit),
    .rise_o (hit_rise)
  );

  hp_edge_det u_heal_edge (
    .pclk   (pclk),
    .rst_n  (rst_n),
    .sig_i  (heal),
    .rise_o (heal_rise)
  );

  assign tick = vblnk_in & ~vblnk_q;

  // game_on low overrides everything, including a hit or heal in the same cycle.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StOff;
      hp_q        <= HpMax;
      icnt_q      <= '0;
      blink_q     <= 3'd0;
      invuln_q    <= 1'b0;
      game_over_q <= 1'b0;
      vblnk_q     <= 1'b0;
    end else begin
      vblnk_q     <= vblnk_in;
      game_over_q <= 1'b0;
      if (tick) begin
        blink_q <= blink_q + 3'd1;
      end
      if (!game_on) begin
        state_q  <= StOff;
        hp_q     <= HpMax;
        icnt_q   <= '0;
        invuln_q <= 1'b0;
      end else begin
        unique case (state_q)
          StOff: begin
            state_q <= StGame;
          end
          StGame: begin
            if (hit_rise) begin
              hp_q <= hp_q - HPW'(1);
              if (hp_q == HPW'(1)) begin
                state_q     <= StDead;
                game_over_q <= 1'b1;
              end else begin
                state_q  <= StInvuln;
                icnt_q   <= IcW'(IFRAMES);
                invuln_q <= 1'b1;
              end
            end else if (heal_rise && (hp_q < HpMax)) begin
              hp_q <= hp_q + HPW'(1);
            end
          end
          StInvuln: begin
            if (heal_rise && (hp_q < HpMax)) begin
              hp_q <= hp_q + HPW'(1);
            end
            if (tick) begin
              if (icnt_q == IcW'(1)) begin
                state_q  <= StGame;
                icnt_q   <= '0;
                invuln_q <= 1'b0;
              end else begin
                icnt_q <= icnt_q - IcW'(1);
              end
            end
          end
          StDead: begin
          end
          default: begin
            state_q <= StOff;
          end
        endcase
      end
    end
  end

  logic [11:0] bar_end;
  logic        in_outer;
  logic        in_int;
  logic        in_bar;
  logic        bar_hidden;
  logic [11:0] rgb_d;

  assign bar_end    = XIntL + 12'(hp_q) * 12'(SEG_W);
  assign in_outer   = (hcount_in >= XOutL) && (hcount_in < XOutR) &&
                      (vcount_in >= YOutT) && (vcount_in < YOutB);
  assign in_int     = (hcount_in >= XIntL) && (hcount_in < XIntR) &&
                      (vcount_in >= YIntT) && (vcount_in < YIntB);
  assign in_bar     = (hcount_in >= XIntL) && (hcount_in < bar_end) &&
                      (vcount_in >= YIntT) && (vcount_in < YIntB);
  assign bar_hidden = (state_q == StInvuln) && blink_q[2];

  always_comb begin
    rgb_d = rgb_in;
    if (state_q != StOff) begin
      if (in_outer && !in_int) begin
        rgb_d = C_FRAME;
      end else if (in_bar && !bar_hidden) begin
        rgb_d = (hp_q > HpLow) ? C_OK : C_LOW;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= 12'd0;
      vcount_out <= 12'd0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= 12'd0;
    end else begin
      hcount_out <= hcount_in;
      vcount_out <= vcount_in;
      hsync_out  <= hsync_in;
      vsync_out  <= vsync_in;
      hblnk_out  <= hblnk_in;
      vblnk_out  <= vblnk_in;
      rgb_out    <= rgb_d;
    end
  end

  assign hp_out    = hp_q;
  assign invuln    = invuln_q;
  assign game_over = game_over_q;

endmodule
